id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register, directly downstream of the control unit. It latches the 8-bit control word and the decoded ID-stage operands for the EX stage.
- Detects load-use hazards against the instruction currently in EX. On a hazard it stalls PC and IF/ID and inserts a bubble.
- Sequences MADDU (opcode 28) as a two-cycle EX operation, holding upstream stages for the extra cycle.
- Keeps a saturating stall counter for performance debug.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/hazard_detect.sv | 20 ++
 rtl/id_ex_pipe_reg.sv | 148 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : opcodes, control-word bit positions and ID/EX FSM states. rev 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [5:0] OP_R_FORMAT = 6'd0;
  localparam logic [5:0] OP_J        = 6'd2;
  localparam logic [5:0] OP_BEQ      = 6'd4;
  localparam logic [5:0] OP_ADDIU    = 6'd9;
  localparam logic [5:0] OP_MADDU    = 6'd28;
  localparam logic [5:0] OP_LW       = 6'd35;
  localparam logic [5:0] OP_SW       = 6'd43;

  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_REGWRITE = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MADDU1 = 1'b1
  } ex_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_detect : load-use compare of the EX load target vs. ID sources. rev 1.0
// ---------------------------------------------------------------------------
module hazard_detect #(
  parameter int RADDR_W = 5
) (
  input  logic               ex_memread_i,
  input  logic [RADDR_W-1:0] ex_rt_i,
  input  logic [RADDR_W-1:0] id_rs_i,
  input  logic [RADDR_W-1:0] id_rt_i,
  output logic               load_use_o
);

  // $zero is never a real dependency, so a load into it cannot stall.
  assign load_use_o = ex_memread_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// id_ex_pipe_reg : ID/EX register with load-use bubbles, two-cycle MADDU
//                  sequencing and a saturating stall counter.       rev 1.0
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         RADDR_W  = 5,
  parameter logic [5:0] MADDU_OP = OP_MADDU,
  parameter int         CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         ID_Opcode,
  input  logic [7:0]         ID_Ctrl,
  input  logic [DATA_W-1:0]  ID_RD1,
  input  logic [DATA_W-1:0]  ID_RD2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [RADDR_W-1:0] ID_Rs,
  input  logic [RADDR_W-1:0] ID_Rt,
  input  logic [RADDR_W-1:0] ID_Rd,
  input  logic [5:0]         ID_Funct,
  input  logic               Flush,
  output logic               Stall,
  output logic [7:0]         EX_Ctrl,
  output logic [DATA_W-1:0]  EX_RD1,
  output logic [DATA_W-1:0]  EX_RD2,
  output logic [DATA_W-1:0]  EX_Imm,
  output logic [RADDR_W-1:0] EX_Rs,
  output logic [RADDR_W-1:0] EX_Rt,
  output logic [RADDR_W-1:0] EX_Rd,
  output logic [5:0]         EX_Funct,
  output logic               EX_IsMaddu,
  output logic               EX_MadduPhase,
  output logic [CNT_W-1:0]   StallCount
);

  ex_state_e          state_q, state_d;
  logic [7:0]         ctrl_q, ctrl_d;
  logic [DATA_W-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [RADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [5:0]         funct_q, funct_d;
  logic               is_maddu_q, is_maddu_d;
  logic               phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu_raw;
  logic               lu;

  hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
    .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i      (rt_q),
    .id_rs_i      (ID_Rs),
    .id_rt_i      (ID_Rt),
    .load_use_o   (lu_raw)
  );

  // Upstream is already frozen during MADDU1, so a hazard there is moot.
  assign lu    = lu_raw && (state_q != MADDU1);
  assign Stall = lu || (state_q == MADDU1);

  always_comb begin
    state_d    = IDLE;
    ctrl_d     = ctrl_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    funct_d    = funct_q;
    is_maddu_d = is_maddu_q;
    phase_d    = phase_q;
    if (state_q == MADDU1) begin
      phase_d = 1'b1;
    end else if (Flush || lu) begin
      ctrl_d     = '0;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      funct_d    = '0;
      is_maddu_d = 1'b0;
      phase_d    = 1'b0;
    end else begin
      ctrl_d     = ID_Ctrl;
      rd1_d      = ID_RD1;
      rd2_d      = ID_RD2;
      imm_d      = ID_Imm;
      rs_d       = ID_Rs;
      rt_d       = ID_Rt;
      rd_d       = ID_Rd;
      funct_d    = ID_Funct;
      is_maddu_d = (ID_Opcode == MADDU_OP);
      phase_d    = 1'b0;
      state_d    = (ID_Opcode == MADDU_OP) ? MADDU1 : IDLE;
    end
  end

  assign cnt_d = (Stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      is_maddu_q <= 1'b0;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      funct_q    <= funct_d;
      is_maddu_q <= is_maddu_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
    end
  end

  assign EX_Ctrl       = ctrl_q;
  assign EX_RD1        = rd1_q;
  assign EX_RD2        = rd2_q;
  assign EX_Imm        = imm_q;
  assign EX_Rs         = rs_q;
  assign EX_Rt         = rt_q;
  assign EX_Rd         = rd_q;
  assign EX_Funct      = funct_q;
  assign EX_IsMaddu    = is_maddu_q;
  assign EX_MadduPhase = phase_q;
  assign StallCount    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg : directed stimulus with a queue-based scoreboard. rev 1.0
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  ID_Opcode = '0;
  logic [7:0]  ID_Ctrl = '0;
  logic [31:0] ID_RD1 = '0, ID_RD2 = '0, ID_Imm = '0;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
  logic [5:0]  ID_Funct = '0;
  logic        Flush = 1'b0;

  logic        Stall, EX_IsMaddu, EX_MadduPhase;
  logic [7:0]  EX_Ctrl;
  logic [31:0] EX_RD1, EX_RD2, EX_Imm;
  logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
  logic [5:0]  EX_Funct;
  logic [15:0] StallCount;

  logic        s_Stall, s_IsMaddu, s_Phase;
  logic [7:0]  s_Ctrl;
  logic [31:0] s_RD1, s_RD2, s_Imm;
  logic [4:0]  s_Rs, s_Rt, s_Rd;
  logic [5:0]  s_Funct;
  logic [3:0]  s_StallCount;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .ID_Opcode(ID_Opcode), .ID_Ctrl(ID_Ctrl),
    .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Funct(ID_Funct), .Flush(Flush),
    .Stall(Stall), .EX_Ctrl(EX_Ctrl), .EX_RD1(EX_RD1), .EX_RD2(EX_RD2),
    .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_Funct(EX_Funct), .EX_IsMaddu(EX_IsMaddu),
    .EX_MadduPhase(EX_MadduPhase), .StallCount(StallCount)
  );

  id_ex_pipe_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ID_Opcode(ID_Opcode), .ID_Ctrl(ID_Ctrl),
    .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm), .ID_Rs(ID_Rs),
    .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Funct(ID_Funct), .Flush(Flush),
    .Stall(s_Stall), .EX_Ctrl(s_Ctrl), .EX_RD1(s_RD1), .EX_RD2(s_RD2),
    .EX_Imm(s_Imm), .EX_Rs(s_Rs), .EX_Rt(s_Rt), .EX_Rd(s_Rd),
    .EX_Funct(s_Funct), .EX_IsMaddu(s_IsMaddu),
    .EX_MadduPhase(s_Phase), .StallCount(s_StallCount)
  );

  typedef struct {
    logic [5:0] op;
    logic [7:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic [7:0] tag;
  } instr_t;

  // stall: Stall seen before the edge; the rest: EX state after the edge.
  typedef struct {
    logic        stall;
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] rd1, rd2, imm;
    logic        ism, ph;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic instr_t mk(logic [5:0] op, logic [7:0] ctrl, logic [4:0] rs,
                                logic [4:0] rt, logic [4:0] rd, logic [7:0] tag);
    instr_t i;
    i.op = op; i.ctrl = ctrl; i.rs = rs; i.rt = rt; i.rd = rd; i.tag = tag;
    return i;
  endfunction

  function automatic logic [5:0] funct_of(logic [7:0] tag);
    return tag[5:0] ^ 6'h20;
  endfunction

  function automatic exp_t e_load(instr_t i, logic stall, logic ism, logic ph, int cnt);
    exp_t e;
    e.stall = stall; e.ctrl = i.ctrl; e.rs = i.rs; e.rt = i.rt; e.rd = i.rd;
    e.funct = funct_of(i.tag);
    e.rd1 = 32'h1000_0000 | 32'(i.tag);
    e.rd2 = 32'h2000_0000 | 32'(i.tag);
    e.imm = 32'h3000_0000 | 32'(i.tag);
    e.ism = ism; e.ph = ph;
    e.cnt = 16'(cnt);
    e.cnt4 = (cnt > 15) ? 4'd15 : 4'(cnt);
    return e;
  endfunction

  function automatic exp_t e_bubble(logic stall, int cnt);
    exp_t e;
    e = e_load(mk(6'd0, 8'h00, 5'd0, 5'd0, 5'd0, 8'd0), stall, 1'b0, 1'b0, cnt);
    e.rd1 = '0; e.rd2 = '0; e.imm = '0; e.funct = '0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(instr_t i, logic flush, logic rstn, exp_t e);
    @(negedge clk);
    ID_Opcode = i.op;  ID_Ctrl = i.ctrl;
    ID_Rs = i.rs;      ID_Rt = i.rt;     ID_Rd = i.rd;
    ID_Funct = funct_of(i.tag);
    ID_RD1 = 32'h1000_0000 | 32'(i.tag);
    ID_RD2 = 32'h2000_0000 | 32'(i.tag);
    ID_Imm = 32'h3000_0000 | 32'(i.tag);
    Flush = flush;
    rst_n = rstn;
    sb.push_back(e);
  endtask

  exp_t mon_e;
  logic mon_st;

  initial begin
    forever begin
      @(negedge clk);
      #2 mon_st = Stall;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("stall",      32'(mon_st),        32'(mon_e.stall));
        chk("ex_ctrl",    32'(EX_Ctrl),       32'(mon_e.ctrl));
        chk("ex_rs",      32'(EX_Rs),         32'(mon_e.rs));
        chk("ex_rt",      32'(EX_Rt),         32'(mon_e.rt));
        chk("ex_rd",      32'(EX_Rd),         32'(mon_e.rd));
        chk("ex_funct",   32'(EX_Funct),      32'(mon_e.funct));
        chk("ex_rd1",     EX_RD1,             mon_e.rd1);
        chk("ex_rd2",     EX_RD2,             mon_e.rd2);
        chk("ex_imm",     EX_Imm,             mon_e.imm);
        chk("ex_ismaddu", 32'(EX_IsMaddu),    32'(mon_e.ism));
        chk("ex_phase",   32'(EX_MadduPhase), 32'(mon_e.ph));
        chk("stallcount", 32'(StallCount),    32'(mon_e.cnt));
        chk("stallcount4", 32'(s_StallCount), 32'(mon_e.cnt4));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, expected end before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t x, lw5, add, lw0, add2, md1, addi, swf, lw10, swlu, md2, addi2, md3, md4, addi3, md;
    x     = mk(6'd0,  8'hFF, 5'd1,  5'd2,  5'd3, 8'd1);
    lw5   = mk(6'd35, 8'h78, 5'd1,  5'd5,  5'd0, 8'd2);
    add   = mk(6'd0,  8'h92, 5'd5,  5'd6,  5'd7, 8'd3);
    lw0   = mk(6'd35, 8'h78, 5'd2,  5'd0,  5'd0, 8'd4);
    add2  = mk(6'd0,  8'h92, 5'd0,  5'd0,  5'd8, 8'd5);
    md1   = mk(6'd28, 8'h12, 5'd3,  5'd4,  5'd0, 8'd6);
    addi  = mk(6'd9,  8'h50, 5'd3,  5'd9,  5'd0, 8'd7);
    swf   = mk(6'd43, 8'h44, 5'd3,  5'd9,  5'd0, 8'd8);
    lw10  = mk(6'd35, 8'h78, 5'd1,  5'd10, 5'd0, 8'd9);
    swlu  = mk(6'd43, 8'h44, 5'd10, 5'd11, 5'd0, 8'd10);
    md2   = mk(6'd28, 8'h12, 5'd3,  5'd4,  5'd0, 8'd11);
    addi2 = mk(6'd9,  8'h50, 5'd3,  5'd9,  5'd0, 8'd12);
    md3   = mk(6'd28, 8'h12, 5'd3,  5'd4,  5'd0, 8'd13);
    md4   = mk(6'd28, 8'h12, 5'd3,  5'd4,  5'd0, 8'd14);
    addi3 = mk(6'd9,  8'h50, 5'd3,  5'd9,  5'd0, 8'd15);

    step(x,     1'b0, 1'b0, e_bubble(1'b0, 0));
    step(x,     1'b0, 1'b1, e_load(x,     1'b0, 1'b0, 1'b0, 0));
    step(lw5,   1'b0, 1'b1, e_load(lw5,   1'b0, 1'b0, 1'b0, 0));
    step(add,   1'b0, 1'b1, e_bubble(1'b1, 1));
    step(add,   1'b0, 1'b1, e_load(add,   1'b0, 1'b0, 1'b0, 1));
    step(lw0,   1'b0, 1'b1, e_load(lw0,   1'b0, 1'b0, 1'b0, 1));
    step(add2,  1'b0, 1'b1, e_load(add2,  1'b0, 1'b0, 1'b0, 1));
    step(md1,   1'b0, 1'b1, e_load(md1,   1'b0, 1'b1, 1'b0, 1));
    step(addi,  1'b0, 1'b1, e_load(md1,   1'b1, 1'b1, 1'b1, 2));
    step(addi,  1'b0, 1'b1, e_load(addi,  1'b0, 1'b0, 1'b0, 2));
    step(swf,   1'b1, 1'b1, e_bubble(1'b0, 2));
    step(lw10,  1'b0, 1'b1, e_load(lw10,  1'b0, 1'b0, 1'b0, 2));
    step(swlu,  1'b1, 1'b1, e_bubble(1'b1, 3));
    step(md2,   1'b0, 1'b1, e_load(md2,   1'b0, 1'b1, 1'b0, 3));
    step(addi2, 1'b1, 1'b1, e_load(md2,   1'b1, 1'b1, 1'b1, 4));
    step(md3,   1'b0, 1'b1, e_load(md3,   1'b0, 1'b1, 1'b0, 4));
    step(md4,   1'b0, 1'b1, e_load(md3,   1'b1, 1'b1, 1'b1, 5));
    step(md4,   1'b0, 1'b1, e_load(md4,   1'b0, 1'b1, 1'b0, 5));

    // Asynchronous reset while the second MADDU is in its MADDU1 cycle.
    @(posedge clk);
    #3;
    chk("pre_rst_stall", 32'(Stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl",   32'(EX_Ctrl),       32'd0);
    chk("rst_rs",     32'(EX_Rs),         32'd0);
    chk("rst_ismaddu", 32'(EX_IsMaddu),   32'd0);
    chk("rst_phase",  32'(EX_MadduPhase), 32'd0);
    chk("rst_count",  32'(StallCount),    32'd0);
    chk("rst_stall",  32'(Stall),         32'd0);

    step(addi3, 1'b0, 1'b1, e_load(addi3, 1'b0, 1'b0, 1'b0, 0));

    for (int k = 1; k <= 20; k++) begin
      md = mk(6'd28, 8'h12, 5'd3, 5'd4, 5'd0, 8'(20 + k));
      step(md, 1'b0, 1'b1, e_load(md, 1'b0, 1'b1, 1'b0, k - 1));
      step(md, 1'b0, 1'b1, e_load(md, 1'b1, 1'b1, 1'b1, k));
    end
    step(addi3, 1'b0, 1'b1, e_load(addi3, 1'b0, 1'b0, 1'b0, 20));

    @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
